// File: rtl/pifo_gpfc_pkg.sv
// Shared definitions for the calendar/GPFC PIFO front end: element
// field layout, bit offsets and the pack/unpack helpers.
`timescale 1ns/100ps
package pifo_gpfc_pkg;

    localparam int ELEMENT_WIDTH      = 40;
    localparam int ELEMENT_RANK_WIDTH = 17;
    localparam int GPFC_COS_WIDTH     = 3;
    localparam int GPFC_RANK_WIDTH    = 6;
    localparam int PKT_ADDRESS_WIDTH  = 12;
    localparam int PIFO_DEPTH         = 16;
    localparam int CNT_WIDTH          = 5;

    localparam int VALID_BIT     = 39;
    localparam int OVF_BIT       = 38;
    localparam int RANK_MSB      = 37;
    localparam int RANK_LSB      = 21;
    localparam int COS_MSB       = 20;
    localparam int COS_LSB       = 18;
    localparam int GPFC_RANK_MSB = 17;
    localparam int GPFC_RANK_LSB = 12;
    localparam int ADDR_MSB      = 11;
    localparam int ADDR_LSB      = 0;

    // Field order matches the bit offsets above, MSB first.
    typedef struct packed {
        logic                          valid;
        logic                          ovf;
        logic [ELEMENT_RANK_WIDTH-1:0] rank;
        logic [GPFC_COS_WIDTH-1:0]     cos;
        logic [GPFC_RANK_WIDTH-1:0]    gpfc_rank;
        logic [PKT_ADDRESS_WIDTH-1:0]  addr;
    } pifo_info_t;

    function automatic logic [ELEMENT_WIDTH-1:0] pack_element(
        input logic                          ovf,
        input logic [ELEMENT_RANK_WIDTH-1:0] rank,
        input logic [GPFC_COS_WIDTH-1:0]     cos,
        input logic [GPFC_RANK_WIDTH-1:0]    gpfc_rank,
        input logic [PKT_ADDRESS_WIDTH-1:0]  addr
    );
        pifo_info_t e;
        e.valid     = 1'b1;
        e.ovf       = ovf;
        e.rank      = rank;
        e.cos       = cos;
        e.gpfc_rank = gpfc_rank;
        e.addr      = addr;
        return e;
    endfunction

    function automatic pifo_info_t unpack_element(input logic [ELEMENT_WIDTH-1:0] raw);
        return pifo_info_t'(raw);
    endfunction

endpackage

// File: rtl/pifo_epoch_tracker.sv
// Holds the global calendar overflow bit and the rank of the last
// dequeued head, derives the epoch bit for an arriving rank, and flags
// pops that move the calendar into the next epoch.
`timescale 1ns/100ps
module pifo_epoch_tracker
    import pifo_gpfc_pkg::*;
#(
    parameter int RANK_W = ELEMENT_RANK_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              update,
    input  logic              head_ovf,
    input  logic [RANK_W-1:0] head_rank,
    input  logic [RANK_W-1:0] enq_rank,
    output logic              g_ovf,
    output logic [RANK_W-1:0] last_rank,
    output logic              ovf,
    output logic              flip
);

    // Virtual time advances to the head that was just popped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            g_ovf     <= 1'b0;
            last_rank <= '0;
        end else if (update) begin
            g_ovf     <= head_ovf;
            last_rank <= head_rank;
        end
    end

    // A rank below virtual time has wrapped and belongs to the next epoch.
    assign ovf  = (enq_rank >= last_rank) ? g_ovf : ~g_ovf;
    assign flip = update & (head_ovf != g_ovf);

endmodule

// File: rtl/pifo_calendar_gpfc_ctrl.sv
// Front-end controller for a systolic calendar/GPFC PIFO array: packs
// enqueue descriptors, issues insert/pop commands, returns dequeued
// heads through a registered response port and tracks occupancy.
`timescale 1ns/100ps
module pifo_calendar_gpfc_ctrl
    import pifo_gpfc_pkg::*;
#(
    parameter int ELEMENT_WIDTH      = pifo_gpfc_pkg::ELEMENT_WIDTH,
    parameter int ELEMENT_RANK_WIDTH = pifo_gpfc_pkg::ELEMENT_RANK_WIDTH,
    parameter int GPFC_COS_WIDTH     = pifo_gpfc_pkg::GPFC_COS_WIDTH,
    parameter int GPFC_RANK_WIDTH    = pifo_gpfc_pkg::GPFC_RANK_WIDTH,
    parameter int PKT_ADDRESS_WIDTH  = pifo_gpfc_pkg::PKT_ADDRESS_WIDTH,
    parameter int PIFO_DEPTH         = pifo_gpfc_pkg::PIFO_DEPTH,
    parameter int CNT_WIDTH          = pifo_gpfc_pkg::CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [ELEMENT_RANK_WIDTH-1:0] enq_rank,
    input  logic [GPFC_COS_WIDTH-1:0]     enq_gpfc_cos,
    input  logic [GPFC_RANK_WIDTH-1:0]    enq_gpfc_rank,
    input  logic [PKT_ADDRESS_WIDTH-1:0]  enq_addr,
    input  logic                          deq_req,
    output logic                          deq_ack,
    output logic [ELEMENT_WIDTH-1:0]      deq_element,
    output logic                          deq_nack,
    output logic [ELEMENT_WIDTH-1:0]      arr_input,
    output logic                          arr_ctl_insert,
    output logic                          arr_ctl_pop,
    output logic                          arr_global_overflow,
    input  logic [ELEMENT_WIDTH-1:0]      arr_head_element,
    output logic [CNT_WIDTH-1:0]          occupancy,
    output logic                          full,
    output logic                          empty
);

    pifo_info_t                    head;
    logic                          pop_fire;
    logic                          enq_fire;
    logic                          g_ovf;
    logic [ELEMENT_RANK_WIDTH-1:0] last_rank;
    logic                          ovf;
    logic                          flip;

    assign head  = unpack_element(arr_head_element);
    assign full  = (occupancy == CNT_WIDTH'(PIFO_DEPTH));
    assign empty = (occupancy == '0);

    // Pop only a real head; an empty-flagged array never sees a pop.
    assign pop_fire = rstn & deq_req & ~empty & head.valid;

    // During an epoch flip the atoms still hold the old global bit, so an
    // element inserted now would be ordered against the wrong epoch.
    assign enq_ready = rstn & ~flip & (~full | pop_fire);
    assign enq_fire  = enq_valid & enq_ready;

    assign arr_ctl_insert      = enq_fire;
    assign arr_ctl_pop         = pop_fire;
    assign arr_global_overflow = g_ovf;
    assign arr_input = enq_fire
                     ? pack_element(ovf, enq_rank, enq_gpfc_cos, enq_gpfc_rank, enq_addr)
                     : '0;

    pifo_epoch_tracker #(
        .RANK_W    (ELEMENT_RANK_WIDTH)
    ) u_epoch (
        .clk       (clk),
        .rstn      (rstn),
        .update    (pop_fire),
        .head_ovf  (head.ovf),
        .head_rank (head.rank),
        .enq_rank  (enq_rank),
        .g_ovf     (g_ovf),
        .last_rank (last_rank),
        .ovf       (ovf),
        .flip      (flip)
    );

    // Occupancy follows the commands issued to the array; insert+pop nets out.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occupancy <= '0;
        end else begin
            case ({enq_fire, pop_fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Registered dequeue response: capture the head as it is popped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            deq_ack     <= 1'b0;
            deq_nack    <= 1'b0;
            deq_element <= '0;
        end else begin
            deq_ack  <= pop_fire;
            deq_nack <= deq_req & empty;
            if (pop_fire) begin
                deq_element <= arr_head_element;
            end
        end
    end

endmodule
